// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle instruction sequencer with PC, retire counter and watchdog
//
// Ports:
//   clk, rstn         clock and synchronous active-low reset
//   start             begin execution at BOOT_PC (accepted in IDLE or HALT only)
//   fetch_en          one-cycle fetch pulse; nextpc is valid alongside it
//   exec_en           one-cycle pulse starting the execute unit
//   exec_done         execute finished (looked at only while waiting on execute)
//   dec_is_mem        instruction needs the memory stage (sampled with exec_done)
//   dec_is_halt       instruction is a halt (sampled with exec_done)
//   br_taken          branch taken (sampled with exec_done)
//   br_target         branch target (sampled with exec_done)
//   mem_en            one-cycle pulse starting the memory access
//   mem_done          memory access finished (looked at only while waiting on memory)
//   wb_en             one-cycle writeback pulse
//   nextpc            PC of the instruction to fetch
//   busy              high while an instruction is in flight
//   halted            high after a halt instruction retires
//   err               high after a watchdog expiry; only rstn clears it
//   retired           count of retired instructions, wraps modulo 2^32
`timescale 1ns/1ps
module core_sequencer #(
  parameter int              PC_W    = 19,
  parameter logic [PC_W-1:0] BOOT_PC = '0,
  parameter int              TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            fetch_en,
  output logic            exec_en,
  input  logic            exec_done,
  input  logic            dec_is_mem,
  input  logic            dec_is_halt,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            mem_en,
  input  logic            mem_done,
  output logic            wb_en,
  output logic [PC_W-1:0] nextpc,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [31:0]     retired
);

  // Watchdog only needs to count up to TIMEOUT-1: the cycle that would reach
  // TIMEOUT goes straight to ERR instead of storing the value.
  localparam int              WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit              WD_ON   = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_EXWAIT,
    S_MEM,
    S_MEMWAIT,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [WD_W-1:0] wd, wd_nx;
  logic            lat_en;
  logic            load_boot;
  logic            fetch_en_nx, exec_en_nx, mem_en_nx, wb_en_nx;
  logic            busy_nx, halted_nx, err_nx;

  // Decode results captured when execute completes; used in WB.
  logic            is_halt_q;
  logic            br_taken_q;
  logic [PC_W-1:0] br_target_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      wd    <= '0;
    end else begin
      state <= state_nx;
      wd    <= wd_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    wd_nx     = wd;
    lat_en    = 1'b0;
    load_boot = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nx  = S_FETCH;
          load_boot = 1'b1;
        end
      end
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_EXWAIT;
        wd_nx    = '0;
      end
      S_EXWAIT: begin
        // done has priority over a watchdog expiry in the same cycle
        if (exec_done) begin
          lat_en   = 1'b1;
          state_nx = dec_is_mem ? S_MEM : S_WB;
        end else if (WD_ON && (wd == WD_LAST)) begin
          state_nx = S_ERR;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      S_MEM: begin
        state_nx = S_MEMWAIT;
        wd_nx    = '0;
      end
      S_MEMWAIT: begin
        if (mem_done) begin
          state_nx = S_WB;
        end else if (WD_ON && (wd == WD_LAST)) begin
          state_nx = S_ERR;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      S_WB:    state_nx = is_halt_q ? S_HALT : S_FETCH;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase

    // Outputs are registered copies of the decode of the next state, so they
    // line up exactly with the state they describe.
    fetch_en_nx = (state_nx == S_FETCH);
    exec_en_nx  = (state_nx == S_EXEC);
    mem_en_nx   = (state_nx == S_MEM);
    wb_en_nx    = (state_nx == S_WB);
    halted_nx   = (state_nx == S_HALT);
    err_nx      = (state_nx == S_ERR);
    busy_nx     = !((state_nx == S_IDLE) || (state_nx == S_HALT) || (state_nx == S_ERR));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      nextpc      <= BOOT_PC;
      retired     <= '0;
      is_halt_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      fetch_en    <= 1'b0;
      exec_en     <= 1'b0;
      mem_en      <= 1'b0;
      wb_en       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (lat_en) begin
        is_halt_q   <= dec_is_halt;
        br_taken_q  <= br_taken;
        br_target_q <= br_target;
      end
      if (load_boot) begin
        nextpc <= BOOT_PC;
      end else if (state == S_WB) begin
        nextpc  <= br_taken_q ? br_target_q : nextpc + 1'b1;
        retired <= retired + 32'd1;
      end
      fetch_en <= fetch_en_nx;
      exec_en  <= exec_en_nx;
      mem_en   <= mem_en_nx;
      wb_en    <= wb_en_nx;
      busy     <= busy_nx;
      halted   <= halted_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench for core_sequencer
`timescale 1ns/1ps
module tb_core_sequencer;
  localparam int              PC_W = 19;
  localparam int              TMO  = 4;
  localparam logic [PC_W-1:0] BOOT = '0;

  localparam int K_FETCH = 0;
  localparam int K_EXEC  = 1;
  localparam int K_MEM   = 2;
  localparam int K_WB    = 3;
  localparam int K_HALT  = 4;
  localparam int K_ERR   = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            exec_done = 1'b0;
  logic            dec_is_mem = 1'b0;
  logic            dec_is_halt = 1'b0;
  logic            br_taken = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic            mem_done = 1'b0;
  logic            fetch_en, exec_en, mem_en, wb_en;
  logic [PC_W-1:0] nextpc;
  logic            busy, halted, err;
  logic [31:0]     retired;

  core_sequencer #(.PC_W(PC_W), .BOOT_PC(BOOT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .fetch_en(fetch_en), .exec_en(exec_en), .exec_done(exec_done),
    .dec_is_mem(dec_is_mem), .dec_is_halt(dec_is_halt),
    .br_taken(br_taken), .br_target(br_target),
    .mem_en(mem_en), .mem_done(mem_done), .wb_en(wb_en),
    .nextpc(nextpc), .busy(busy), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              de;
    int              dm;
    bit              is_mem;
    bit              halt;
    bit              br;
    logic [PC_W-1:0] tgt;
  } instr_t;

  typedef struct {
    int              kind;
    longint          at;
    logic [PC_W-1:0] pc;
    logic [31:0]     ret;
  } ev_t;

  instr_t plan[$];
  instr_t prog[$];
  ev_t    exp_q[$];
  bit     resp_on = 1'b0;
  int     checks = 0;
  int     errors = 0;
  longint m_pc = 0;
  longint m_ret = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic instr_t mk(input int de, input int dm, input bit m, input bit h,
                                input bit b, input logic [PC_W-1:0] t);
    instr_t r;
    r.de = de; r.dm = dm; r.is_mem = m; r.halt = h; r.br = b; r.tgt = t;
    return r;
  endfunction

  task automatic push(input int k, input longint at, input longint pc, input longint ret);
    ev_t e;
    e.kind = k; e.at = at; e.pc = PC_W'(pc); e.ret = 32'(ret);
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d required=none (cycle %0d)", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", longint'(k), longint'(e.kind));
    chk("event_cycle", cyc, e.at);
    if (k == K_FETCH || k == K_HALT) begin
      chk("nextpc", longint'(nextpc), longint'(e.pc));
      chk("retired", longint'(retired), longint'(e.ret));
    end
    if (k == K_HALT) chk("halt_busy", longint'(busy), 0);
  endtask

  // Monitor: turns DUT outputs into events and scores them against exp_q.
  logic halted_d = 1'b0;
  logic err_d = 1'b0;
  always @(negedge clk) begin : monitor
    int np;
    np = int'(fetch_en) + int'(exec_en) + int'(mem_en) + int'(wb_en);
    if (np != 0) chk("one_pulse", longint'(np <= 1), 1);
    if (fetch_en) observe(K_FETCH);
    if (exec_en)  observe(K_EXEC);
    if (mem_en)   observe(K_MEM);
    if (wb_en)    observe(K_WB);
    if (halted && !halted_d) observe(K_HALT);
    if (err && !err_d)       observe(K_ERR);
    halted_d = halted;
    err_d    = err;
  end

  // Responder: plays the execute and memory units from the program queue.
  always begin : responder
    instr_t d;
    @(negedge clk);
    if (resp_on && exec_en && prog.size() != 0) begin
      d = prog.pop_front();
      repeat (d.de) @(negedge clk);
      exec_done   = 1'b1;
      dec_is_mem  = d.is_mem;
      dec_is_halt = d.halt;
      br_taken    = d.br;
      br_target   = d.tgt;
      @(negedge clk);
      exec_done   = 1'b0;
      dec_is_mem  = 1'($urandom);
      dec_is_halt = 1'($urandom);
      br_taken    = 1'($urandom);
      br_target   = PC_W'($urandom);
      if (d.is_mem) begin
        repeat (d.dm) @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
      end
    end
  end

  // Reference model: per-instruction cycle arithmetic from the start cycle.
  task automatic run_plan();
    longint f, w;
    @(negedge clk);
    prog = plan;
    f = cyc + 1;
    m_pc = longint'(BOOT);
    foreach (plan[i]) begin
      push(K_FETCH, f, m_pc, m_ret);
      push(K_EXEC, f + 2, 0, 0);
      if (plan[i].is_mem) begin
        push(K_MEM, f + 3 + plan[i].de, 0, 0);
        w = f + 4 + plan[i].de + plan[i].dm;
      end else begin
        w = f + 3 + plan[i].de;
      end
      push(K_WB, w, 0, 0);
      m_ret = (m_ret + 1) % (longint'(1) << 32);
      m_pc  = plan[i].br ? longint'(plan[i].tgt) : (m_pc + 1) % (longint'(1) << PC_W);
      f = w + 1;
      if (plan[i].halt) begin
        push(K_HALT, w + 1, m_pc, m_ret);
        break;
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the scoreboard to empty; pokes start while busy, which must be ignored.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      start = busy && ($urandom_range(0, 7) == 0);
      n++;
    end
    start = 1'b0;
    chk("drain_left", longint'(exp_q.size()), 0);
  endtask

  initial begin
    int n;
    int waited;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_halted", longint'(halted), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_retired", longint'(retired), 0);
    chk("rst_nextpc", longint'(nextpc), longint'(BOOT));
    chk("rst_pulses", longint'({fetch_en, exec_en, mem_en, wb_en}), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Directed program: plain, memory, branch, branch to top, wrap, halt.
    resp_on = 1'b1;
    plan = {};
    plan.push_back(mk(1, 0, 1'b0, 1'b0, 1'b0, '0));
    plan.push_back(mk(1, 3, 1'b1, 1'b0, 1'b0, '0));
    plan.push_back(mk(2, 0, 1'b0, 1'b0, 1'b1, 19'h01234));
    plan.push_back(mk(1, 2, 1'b1, 1'b0, 1'b1, 19'h7FFFF));
    plan.push_back(mk(4, 0, 1'b0, 1'b0, 1'b0, 19'h00055));
    plan.push_back(mk(1, 0, 1'b0, 1'b1, 1'b0, '0));
    run_plan();
    drain(400);
    repeat (5) @(negedge clk);
    chk("halt_frozen_pc", longint'(nextpc), m_pc);
    chk("halt_state", longint'(halted), 1);

    // Random programs, each ending in a halt; each restart checks retired retention.
    for (int r = 0; r < 4; r++) begin
      plan = {};
      n = $urandom_range(4, 9);
      for (int i = 0; i < n; i++) begin
        plan.push_back(mk($urandom_range(1, TMO), $urandom_range(1, TMO),
                          1'($urandom), (i == n - 1), ($urandom_range(0, 3) == 0),
                          PC_W'($urandom)));
      end
      run_plan();
      drain(600);
      chk("rand_halted", longint'(halted), 1);
    end
    resp_on = 1'b0;

    // Reset during MEMWAIT; a later mem_done must produce nothing.
    @(negedge clk);
    push(K_FETCH, cyc + 1, longint'(BOOT), m_ret);
    push(K_EXEC, cyc + 3, 0, 0);
    push(K_MEM, cyc + 5, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!exec_en && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_test_exec_seen", longint'(exec_en), 1);
    @(negedge clk);
    exec_done = 1'b1; dec_is_mem = 1'b1; dec_is_halt = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    exec_done = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_retired", longint'(retired), 0);
    chk("midrst_nextpc", longint'(nextpc), longint'(BOOT));
    m_ret = 0;
    rstn = 1'b1;
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_idle", longint'(busy), 0);
    chk("midrst_queue", longint'(exp_q.size()), 0);

    // Watchdog: exec_done never arrives, ERR after 4 EXWAIT cycles.
    @(negedge clk);
    push(K_FETCH, cyc + 1, longint'(BOOT), m_ret);
    push(K_EXEC, cyc + 3, 0, 0);
    push(K_ERR, cyc + 4 + TMO, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("wd_err", longint'(err), 1);
    chk("wd_busy", longint'(busy), 0);
    chk("wd_queue", longint'(exp_q.size()), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wd_err_sticky", longint'(err), 1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("wd_err_cleared", longint'(err), 0);
    chk("wd_idle_busy", longint'(busy), 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the core. Drives the per-stage enable pulses (fetch, execute, memory, writeback) in order, waits on the variable-latency execute and memory units, owns the program-counter register feeding the fetch stage, and counts retired instructions. It sits above the fetch/decode/exec/mem/wb stage modules. It is the only block that starts, advances or stops instruction processing.

## Interface
Parameters:
- PC_W, 19, program-counter width in words.
- BOOT_PC, 0, PC loaded at reset and on start.
- TIMEOUT, 1024, maximum wait cycles for exec_done/mem_done; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  begin execution at BOOT_PC; honoured only in IDLE or HALT.
- fetch_en  out  1  one-cycle pulse; the fetch stage raises decode_en on the next cycle.
- exec_en  out  1  one-cycle pulse starting the execute unit.
- exec_done  in  1  execute finished; valid from the cycle after exec_en.
- dec_is_mem  in  1  current instruction needs the memory stage; sampled with exec_done.
- dec_is_halt  in  1  current instruction is halt; sampled with exec_done.
- br_taken  in  1  branch taken; sampled with exec_done.
- br_target  in  PC_W  branch target; sampled with exec_done.
- mem_en  out  1  one-cycle pulse starting the load/store/IO access.
- mem_done  in  1  memory access finished; valid from the cycle after mem_en.
- wb_en  out  1  one-cycle writeback pulse.
- nextpc  out  PC_W  PC of the instruction to fetch; stable throughout FETCH.
- busy  out  1  high in every state except IDLE, HALT and ERR.
- halted  out  1  high in HALT.
- err  out  1  high in ERR (watchdog expiry).
- retired  out  32  count of completed instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, EXWAIT, MEM, MEMWAIT, WB, HALT, ERR. All outputs are registered.
- IDLE: all pulses 0. When start=1, nextpc<=BOOT_PC and the block moves to FETCH.
- FETCH: fetch_en=1 for this cycle only. Always moves to DECODE.
- DECODE: 1 cycle, no outputs. Always moves to EXEC.
- EXEC: exec_en=1 for 1 cycle. Always moves to EXWAIT.
- EXWAIT: waits for exec_done=1.
  - On exec_done, latch dec_is_mem, dec_is_halt, br_taken and br_target.
  - Go to MEM if is_mem=1, otherwise go to WB.
- MEM: mem_en=1 for 1 cycle. Always moves to MEMWAIT.
- MEMWAIT: waits for mem_done=1, then moves to WB.
- WB: wb_en=1 for 1 cycle and retired increments.
  - nextpc <= br_taken ? br_target : nextpc+1. The add wraps modulo 2^PC_W.
  - Go to HALT if is_halt=1, otherwise go to FETCH.
- HALT: halted=1 and nextpc holds its value. start=1 reloads BOOT_PC and moves to FETCH; retired is not cleared.
- ERR: err=1 and all pulses 0. Only rstn leaves ERR.
- Watchdog counter:
  - Cleared on entering EXWAIT or MEMWAIT.
  - Increments on each cycle in those states while done=0.
  - When the count reaches TIMEOUT with done still 0, the next state is ERR.
  - If done arrives in that same cycle, done wins and there is no ERR.
- exec_done and mem_done outside their own wait state are ignored. start outside IDLE/HALT is ignored.
- Reset, including mid-instruction: state<=IDLE, nextpc<=BOOT_PC, retired<=0, all pulses, busy, halted and err <=0, watchdog<=0. Reset overrides every other input.

## Timing
- start seen at cycle t gives FETCH at t+1 (fetch_en=1, nextpc=BOOT_PC), DECODE at t+2, EXEC at t+3.
- Minimum non-memory instruction: 5 cycles (FETCH, DECODE, EXEC, EXWAIT with done, WB).
- Minimum memory instruction: 7 cycles.
- Each extra done delay adds 1 cycle per wait state.
- New nextpc is visible in the cycle after WB, which is the next FETCH.
- Throughout the run, fetch_en, exec_en, mem_en and wb_en are never high together (at most one at a time).
- retired updates in the cycle after WB.

## Test plan
- Reset, then start at t=0 with exec_done 1 cycle after exec_en and is_mem=0:
  - fetch_en at t=1, exec_en at t=3, wb_en at t=5, fetch_en again at t=6 with nextpc=1, retired=1.
- Memory instruction with mem_done 3 cycles after mem_en:
  - wb_en exactly 4 cycles after mem_en; retired increments once.
- br_taken=1 and br_target=0x1234 at exec_done:
  - next FETCH shows nextpc=0x1234.
  - From nextpc=0x7FFFF with no branch, nextpc wraps to 0.
- dec_is_halt=1:
  - wb_en pulses, then halted=1, busy=0 and nextpc frozen.
  - start then restarts at BOOT_PC with retired retained.
- TIMEOUT=4 and exec_done never asserted:
  - err=1 after 4 EXWAIT cycles and no further pulses; rstn=0 clears err and returns to IDLE.
  - Separately, exec_done exactly on the 4th cycle continues normally with no err.
- rstn=0 asserted during MEMWAIT:
  - next cycle IDLE, retired=0, nextpc=BOOT_PC.
  - A later mem_done produces no response.
